rtc_time_reader: RTL and testbench
==================================

RTC_TIME_READER -- requirements
Module: rtc_time_reader

Interface
REQ-001 The module SHALL have parameter RTC_ADDR, default 7'h68, the 7-bit I2C slave address of the RTC.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 24'd5_000_000, the clk_sys cycles allowed from request to last byte.
REQ-003 clk_sys  in  1  single system clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 tick_1hz  in  1  one-cycle poll request pulse.
REQ-006 i2c_ready  in  1  I2C core idle/accepting (the core's in_ready).
REQ-007 i2c_rd_address  out  1  one-cycle read-start pulse to the core.
REQ-008 i2c_data_address  out  7  slave address; constant RTC_ADDR.
REQ-009 i2c_byte_read  out  8  bytes per transaction; constant 8'd3.
REQ-010 i2c_out_valid  in  1  received-byte strobe from the core.
REQ-011 i2c_out_data  in  8  received byte, valid when i2c_out_valid=1.
REQ-012 time_sec  out  6  seconds, binary 0-59.
REQ-013 time_min  out  6  minutes, binary 0-59.
REQ-014 time_hour  out  5  hours, binary 0-23.
REQ-015 time_valid  out  1  one-cycle pulse when the time outputs update.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 error  out  1  one-cycle pulse on timeout or an invalid BCD byte.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, REQUEST, WAIT_START, COLLECT, CHECK.
- IDLE -> REQUEST when the pending flag is 1.
- REQUEST -> WAIT_START when i2c_ready=1.
- WAIT_START -> COLLECT when i2c_ready=0.
- COLLECT -> CHECK when the 3rd byte is captured.
- CHECK -> IDLE unconditionally, after one cycle.
REQ-019 The pending flag SHALL be set by tick_1hz in any state and cleared in the cycle REQUEST drives i2c_rd_address; ticks arriving while pending=1 are merged.
REQ-020 i2c_rd_address SHALL be asserted for exactly one cycle, only in REQUEST, and only when i2c_ready=1.
REQ-021 In COLLECT, a 2-bit byte counter SHALL store successive i2c_out_valid bytes into raw_sec, raw_min and raw_hour, in that order.
REQ-022 i2c_out_valid SHALL be ignored outside COLLECT.
REQ-023 The byte counter SHALL clear on entry to REQUEST.
REQ-024 A byte arriving in the same cycle WAIT_START exits SHALL still be captured as byte 0.
REQ-025 BCD decode: sec/min binary = tens*10 + units, with tens = bits[6:4] and units = bits[3:0]; bit 7 is ignored.
REQ-026 Hour decode: binary = bits[5:4]*10 + bits[3:0].
REQ-027 Bit 6 of the hour byte (12-hour mode) SHALL be treated as invalid.
REQ-028 A byte SHALL be invalid if units>9, or sec/min tens>5, or decoded hour>23.
REQ-029 In CHECK, if all three bytes are valid, time_* SHALL update and time_valid SHALL pulse in the same cycle.
REQ-030 In CHECK, if any byte is invalid, time_* SHALL hold and error SHALL pulse instead.
REQ-031 A timeout counter SHALL clear on entry to REQUEST and increment every cycle while busy=1.
REQ-032 When the timeout counter reaches TIMEOUT_CYCLES-1 before CHECK, the FSM SHALL return to IDLE and error SHALL pulse.
REQ-033 On timeout, time_* SHALL hold and the pending flag SHALL be preserved.
REQ-034 time_valid and error SHALL never be asserted in the same cycle.

Reset
REQ-035 While reset_n=0, the FSM SHALL be in IDLE and pending, the byte counter, the timeout counter and all raw registers SHALL be 0.
REQ-036 While reset_n=0, time_sec=0, time_min=0, time_hour=0, and time_valid, error, busy and i2c_rd_address SHALL all be 0.
REQ-037 Reset asserted mid-transaction SHALL abandon it with no time_valid or error pulse; bytes arriving after reset release SHALL be ignored (FSM in IDLE).

Verification
REQ-038 Normal read: tick, i2c_ready 1->0, bytes 8'h45, 8'h59, 8'h23 -> one rd pulse, then time 23:59:45 with a single time_valid pulse.
REQ-039 Invalid BCD: bytes 8'h5A, 8'h00, 8'h00 -> error pulse, no time_valid, time_* unchanged.
REQ-040 12-hour flag: hour byte 8'h52 -> error pulse, no time_valid, time_* unchanged.
REQ-041 Timeout: TIMEOUT_CYCLES=100 with only 2 bytes delivered -> error at cycle 99 after REQUEST entry, then IDLE with busy=0.
REQ-042 Busy core: tick while i2c_ready=0 for 50 cycles -> no rd pulse until i2c_ready=1, then exactly one rd pulse.
REQ-043 Merged ticks and reset: two ticks during COLLECT -> exactly one follow-up transaction; reset_n low after byte 1 -> all outputs 0, no pulses.

Source files
------------

// File: rtl/rtc_time_reader.sv
// Polls an I2C RTC for seconds/minutes/hours (BCD), validates the bytes and
// publishes binary time, with a whole-transaction timeout.
module rtc_time_reader #(
    parameter logic [6:0]  RTC_ADDR       = 7'h68,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       i2c_ready,
    output logic       i2c_rd_address,
    output logic [6:0] i2c_data_address,
    output logic [7:0] i2c_byte_read,
    input  logic       i2c_out_valid,
    input  logic [7:0] i2c_out_data,
    output logic [5:0] time_sec,
    output logic [5:0] time_min,
    output logic [4:0] time_hour,
    output logic       time_valid,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_START,
        COLLECT,
        CHECK
    } state_t;

    state_t      state;
    logic        pending;
    logic [1:0]  byte_cnt;
    logic [23:0] timeout_cnt;
    logic [7:0]  raw_sec;
    logic [7:0]  raw_min;
    logic [7:0]  raw_hour;

    logic        timeout_hit;
    logic        rd_fire;
    logic        capture;
    logic        all_ok;
    logic [5:0]  sec_bin;
    logic [5:0]  min_bin;
    logic [5:0]  hour_bin;

    // Seconds/minutes: bit 7 (clock-halt on most RTCs) is ignored.
    function automatic logic ms_ok(input logic [7:0] b);
        return (b[3:0] <= 4'd9) && (b[6:4] <= 3'd5);
    endfunction

    function automatic logic [5:0] ms_bin(input logic [7:0] b);
        logic [5:0] tens;
        tens = {3'b000, b[6:4]};
        return (tens * 6'd10) + {2'b00, b[3:0]};
    endfunction

    function automatic logic [5:0] hour_val(input logic [7:0] b);
        logic [5:0] tens;
        tens = {4'b0000, b[5:4]};
        return (tens * 6'd10) + {2'b00, b[3:0]};
    endfunction

    // 12-hour mode (bit 6) is not supported and is rejected outright.
    function automatic logic hour_ok(input logic [7:0] b);
        return !b[6] && (b[3:0] <= 4'd9) && (hour_val(b) <= 6'd23);
    endfunction

    assign timeout_hit = (state == REQUEST || state == WAIT_START || state == COLLECT)
                         && (timeout_cnt == TIMEOUT_CYCLES - 24'd1);
    assign rd_fire     = (state == REQUEST) && i2c_ready && !timeout_hit;
    // A byte landing in the same cycle the core goes busy is the first byte.
    assign capture     = i2c_out_valid && !timeout_hit
                         && ((state == COLLECT) || (state == WAIT_START && !i2c_ready));
    assign all_ok      = ms_ok(raw_sec) && ms_ok(raw_min) && hour_ok(raw_hour);
    assign sec_bin     = ms_bin(raw_sec);
    assign min_bin     = ms_bin(raw_min);
    assign hour_bin    = hour_val(raw_hour);

    assign i2c_rd_address   = rd_fire;
    assign i2c_data_address = RTC_ADDR;
    assign i2c_byte_read    = 8'd3;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            byte_cnt    <= 2'd0;
            timeout_cnt <= 24'd0;
            raw_sec     <= 8'd0;
            raw_min     <= 8'd0;
            raw_hour    <= 8'd0;
            time_sec    <= 6'd0;
            time_min    <= 6'd0;
            time_hour   <= 5'd0;
            time_valid  <= 1'b0;
            error       <= 1'b0;
        end else begin
            time_valid <= 1'b0;
            error      <= 1'b0;

            // Ticks while a request is already pending collapse into it.
            if (rd_fire)
                pending <= 1'b0;
            else if (tick_1hz)
                pending <= 1'b1;

            if (state != IDLE)
                timeout_cnt <= timeout_cnt + 24'd1;

            if (capture) begin
                case (byte_cnt)
                    2'd0:    raw_sec  <= i2c_out_data;
                    2'd1:    raw_min  <= i2c_out_data;
                    default: raw_hour <= i2c_out_data;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (timeout_hit) begin
                state <= IDLE;
                error <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            state       <= REQUEST;
                            byte_cnt    <= 2'd0;
                            timeout_cnt <= 24'd0;
                        end
                    end
                    REQUEST: begin
                        if (i2c_ready)
                            state <= WAIT_START;
                    end
                    WAIT_START: begin
                        if (!i2c_ready)
                            state <= COLLECT;
                    end
                    COLLECT: begin
                        if (capture && byte_cnt == 2'd2)
                            state <= CHECK;
                    end
                    CHECK: begin
                        state <= IDLE;
                        if (all_ok) begin
                            time_sec   <= sec_bin;
                            time_min   <= min_bin;
                            time_hour  <= hour_bin[4:0];
                            time_valid <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Self-checking bench for rtc_time_reader: directed decode cases, randomized
// reads against a BCD reference model, busy core, timeout, merged ticks, reset.
module tb_rtc_time_reader;

    localparam logic [23:0] TC = 24'd100;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       i2c_ready = 1'b1;
    logic       i2c_rd_address;
    logic [6:0] i2c_data_address;
    logic [7:0] i2c_byte_read;
    logic       i2c_out_valid = 1'b0;
    logic [7:0] i2c_out_data = 8'd0;
    logic [5:0] time_sec;
    logic [5:0] time_min;
    logic [4:0] time_hour;
    logic       time_valid;
    logic       busy;
    logic       error;

    int total = 0;
    int bad = 0;
    int rd_cnt = 0;
    int tv_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int exp_s = 0;
    int exp_m = 0;
    int exp_h = 0;

    rtc_time_reader #(.RTC_ADDR(7'h68), .TIMEOUT_CYCLES(TC)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .tick_1hz(tick_1hz),
        .i2c_ready(i2c_ready),
        .i2c_rd_address(i2c_rd_address),
        .i2c_data_address(i2c_data_address),
        .i2c_byte_read(i2c_byte_read),
        .i2c_out_valid(i2c_out_valid),
        .i2c_out_data(i2c_out_data),
        .time_sec(time_sec),
        .time_min(time_min),
        .time_hour(time_hour),
        .time_valid(time_valid),
        .busy(busy),
        .error(error)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (i2c_rd_address) rd_cnt <= rd_cnt + 1;
        if (time_valid) tv_cnt <= tv_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (time_valid && error) both_cnt <= both_cnt + 1;
    end

    // Reference: RTC BCD registers to binary time, plain integer arithmetic.
    function automatic bit ref_decode(input logic [7:0] bs, input logic [7:0] bm,
                                      input logic [7:0] bh, output int s, output int m,
                                      output int h);
        int st, su, mt, mu, ht, hu;
        st = (int'(bs) / 16) % 8;  su = int'(bs) % 16;
        mt = (int'(bm) / 16) % 8;  mu = int'(bm) % 16;
        ht = (int'(bh) / 16) % 4;  hu = int'(bh) % 16;
        s = st * 10 + su;
        m = mt * 10 + mu;
        h = ht * 10 + hu;
        return (su < 10) && (st < 6) && (mu < 10) && (mt < 6)
               && (((int'(bh) / 64) % 2) == 0) && (hu < 10) && (h < 24);
    endfunction

    task automatic tick_pulse();
        @(posedge clk_sys); #1 tick_1hz = 1'b1;
        @(posedge clk_sys); #1 tick_1hz = 1'b0;
    endtask

    task automatic wait_rd(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_sys);
            if (i2c_rd_address) seen = 1'b1;
        end
    endtask

    // Called right after the read pulse was seen; returns the pulses in the
    // cycle following CHECK.
    task automatic deliver(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input bit same, output bit tv, output bit er);
        logic [7:0] bytes [3];
        bytes = '{b0, b1, b2};
        @(posedge clk_sys); #1 i2c_ready = 1'b0;
        if (same) begin
            i2c_out_valid = 1'b1;
            i2c_out_data  = b0;
        end
        @(posedge clk_sys); #1 i2c_out_valid = 1'b0;
        for (int i = (same ? 1 : 0); i < 3; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk_sys); #1 i2c_out_data = 8'($urandom);
            end
            i2c_out_valid = 1'b1;
            i2c_out_data  = bytes[i];
            @(posedge clk_sys); #1 i2c_out_valid = 1'b0;
        end
        @(posedge clk_sys); #1;
        tv = time_valid;
        er = error;
        i2c_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick_1hz = 1'b1;
        repeat (3) @(negedge clk_sys);
        total++; if (time_sec !== 6'd0) begin bad++; $display("FAIL reset_sec: got %0d want 0", time_sec); end
        total++; if (time_min !== 6'd0) begin bad++; $display("FAIL reset_min: got %0d want 0", time_min); end
        total++; if (time_hour !== 5'd0) begin bad++; $display("FAIL reset_hour: got %0d want 0", time_hour); end
        total++; if ({time_valid, error, busy, i2c_rd_address} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got tv/err/busy/rd=%b want 0000", {time_valid, error, busy, i2c_rd_address});
        end
        total++; if ({i2c_data_address, i2c_byte_read} !== {7'h68, 8'd3}) begin
            bad++; $display("FAIL const_ports: got addr=%h n=%0d want 68/3", i2c_data_address, i2c_byte_read);
        end
        @(posedge clk_sys); #1 tick_1hz = 1'b0; reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_tick_ignored: busy=%b want 0", busy); end
    endtask

    task automatic test_decode_cases();
        logic [7:0] t0 [9] = '{8'h45, 8'h5A, 8'h45, 8'h07, 8'hD9, 8'h00, 8'h00, 8'h59, 8'h00};
        logic [7:0] t1 [9] = '{8'h59, 8'h00, 8'h59, 8'h30, 8'hA5, 8'h60, 8'h00, 8'h59, 8'h00};
        logic [7:0] t2 [9] = '{8'h23, 8'h00, 8'h52, 8'h12, 8'h09, 8'h00, 8'h24, 8'h19, 8'h2A};
        bit         sm [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            bit seen, tv, er, ok;
            int s, m, h, r0, v0, e0;
            r0 = rd_cnt; v0 = tv_cnt; e0 = err_cnt;
            tick_pulse();
            wait_rd(seen);
            total++; if (!seen) begin bad++; $display("FAIL decode[%0d]_rd: no read pulse within bound", k); end
            if (seen) begin
                deliver(t0[k], t1[k], t2[k], sm[k], tv, er);
                ok = ref_decode(t0[k], t1[k], t2[k], s, m, h);
                if (ok) begin exp_s = s; exp_m = m; exp_h = h; end
                total++; if (tv !== ok) begin bad++; $display("FAIL decode[%0d]_tv: got %0b want %0b", k, tv, ok); end
                total++; if (er !== !ok) begin bad++; $display("FAIL decode[%0d]_err: got %0b want %0b", k, er, !ok); end
                total++; if ({time_hour, time_min, time_sec} !== {5'(exp_h), 6'(exp_m), 6'(exp_s)}) begin
                    bad++; $display("FAIL decode[%0d]_time: got %0d:%0d:%0d want %0d:%0d:%0d", k,
                                    time_hour, time_min, time_sec, exp_h, exp_m, exp_s);
                end
                if (k == 0) begin
                    total++; if ({time_hour, time_min, time_sec} !== {5'd23, 6'd59, 6'd45}) begin
                        bad++; $display("FAIL decode_2359_45: got %0d:%0d:%0d want 23:59:45", time_hour, time_min, time_sec);
                    end
                end
                repeat (3) @(negedge clk_sys);
                total++; if ((rd_cnt - r0) != 1 || (tv_cnt - v0) != int'(ok) || (err_cnt - e0) != int'(!ok)) begin
                    bad++; $display("FAIL decode[%0d]_pulses: got rd=%0d tv=%0d err=%0d want 1/%0d/%0d", k,
                                    rd_cnt - r0, tv_cnt - v0, err_cnt - e0, ok, !ok);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            bit seen, tv, er, ok;
            int s, m, h;
            logic [7:0] bs, bm, bh;
            s = $urandom_range(0, 59); m = $urandom_range(0, 59); h = $urandom_range(0, 23);
            bs = 8'((s / 10) * 16 + (s % 10)); bs[7] = 1'($urandom_range(0, 1));
            bm = 8'((m / 10) * 16 + (m % 10)); bm[7] = 1'($urandom_range(0, 1));
            bh = 8'((h / 10) * 16 + (h % 10));
            case ($urandom_range(0, 5))
                0: bs = 8'($urandom);
                1: bm = 8'($urandom);
                2: bh = 8'($urandom_range(0, 127));
                default: ;
            endcase
            repeat ($urandom_range(1, 4)) @(posedge clk_sys);
            tick_pulse();
            wait_rd(seen);
            total++; if (!seen) begin bad++; $display("FAIL random[%0d]_rd: no read pulse within bound", k); end
            if (seen) begin
                deliver(bs, bm, bh, 1'($urandom_range(0, 1)), tv, er);
                ok = ref_decode(bs, bm, bh, s, m, h);
                if (ok) begin exp_s = s; exp_m = m; exp_h = h; end
                total++; if ({tv, er} !== {ok, !ok}) begin
                    bad++; $display("FAIL random[%0d]_pulse: bytes %h %h %h got tv=%b err=%b want %b/%b", k,
                                    bs, bm, bh, tv, er, ok, !ok);
                end
                total++; if ({time_hour, time_min, time_sec} !== {5'(exp_h), 6'(exp_m), 6'(exp_s)}) begin
                    bad++; $display("FAIL random[%0d]_time: got %0d:%0d:%0d want %0d:%0d:%0d", k,
                                    time_hour, time_min, time_sec, exp_h, exp_m, exp_s);
                end
            end
        end
    endtask

    task automatic test_busy_core();
        bit seen, tv, er;
        int r0;
        repeat (2) @(posedge clk_sys);
        #1 i2c_ready = 1'b0;
        r0 = rd_cnt;
        tick_pulse();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_sys); #1;
            i2c_out_valid = (i % 7 == 3);
            i2c_out_data  = 8'($urandom);
        end
        i2c_out_valid = 1'b0;
        @(negedge clk_sys);
        total++; if (rd_cnt != r0 || busy !== 1'b1) begin
            bad++; $display("FAIL busy_hold: got rd=%0d busy=%b want 0/1", rd_cnt - r0, busy);
        end
        @(posedge clk_sys); #1 i2c_ready = 1'b1;
        wait_rd(seen);
        total++; if (!seen) begin bad++; $display("FAIL busy_rd: no read pulse after ready"); end
        if (seen) begin
            deliver(8'h12, 8'h34, 8'h08, 1'b0, tv, er);
            exp_s = 12; exp_m = 34; exp_h = 8;
            total++; if ({tv, er, time_hour, time_min, time_sec} !== {2'b10, 5'd8, 6'd34, 6'd12}) begin
                bad++; $display("FAIL busy_result: got tv=%b err=%b %0d:%0d:%0d want 1/0 8:34:12",
                                tv, er, time_hour, time_min, time_sec);
            end
        end
        repeat (10) @(negedge clk_sys);
        total++; if (rd_cnt - r0 != 1) begin bad++; $display("FAIL busy_one_rd: got %0d pulses want 1", rd_cnt - r0); end
    endtask

    // Cycle 0 is the first REQUEST cycle; the counter hits TC-1 in cycle 99
    // and the registered error pulse shows in cycle 100 with the FSM idle.
    task automatic test_timeout();
        int r0, v0, e0, err_cyc, tv_cyc;
        bit found, busy_at_err, busy99;
        r0 = rd_cnt; v0 = tv_cnt; e0 = err_cnt;
        err_cyc = -1; tv_cyc = -1; found = 1'b0; busy_at_err = 1'b1; busy99 = 1'b0;
        tick_pulse();
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk_sys);
            if (busy) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL timeout_start: busy never rose"); end
        for (int c = 0; c <= 130 && found; c++) begin
            if (c > 0) @(negedge clk_sys);
            if (error && err_cyc < 0) begin err_cyc = c; busy_at_err = busy; end
            if (time_valid && tv_cyc < 0) tv_cyc = c;
            if (c == 99) busy99 = busy;
            case (c)
                1:   i2c_ready = 1'b0;
                3:   begin i2c_out_valid = 1'b1; i2c_out_data = 8'h45; end
                6:   begin i2c_out_valid = 1'b1; i2c_out_data = 8'h59; end
                50:  tick_1hz = 1'b1;
                51:  tick_1hz = 1'b0;
                110: i2c_ready = 1'b1;
                111: i2c_ready = 1'b0;
                113: begin i2c_out_valid = 1'b1; i2c_out_data = 8'h11; end
                115: begin i2c_out_valid = 1'b1; i2c_out_data = 8'h22; end
                117: begin i2c_out_valid = 1'b1; i2c_out_data = 8'h13; end
                120: i2c_ready = 1'b1;
                default: i2c_out_valid = 1'b0;
            endcase
        end
        i2c_out_valid = 1'b0;
        total++; if (err_cyc != 100) begin bad++; $display("FAIL timeout_cycle: got error at %0d want 100", err_cyc); end
        total++; if (busy_at_err !== 1'b0 || busy99 !== 1'b1) begin
            bad++; $display("FAIL timeout_busy: got busy@99=%b busy@err=%b want 1/0", busy99, busy_at_err);
        end
        exp_s = 11; exp_m = 22; exp_h = 13;
        total++; if (tv_cyc != 119) begin bad++; $display("FAIL timeout_pending_retry: got time_valid at %0d want 119", tv_cyc); end
        total++; if ({time_hour, time_min, time_sec} !== {5'd13, 6'd22, 6'd11}) begin
            bad++; $display("FAIL timeout_time: got %0d:%0d:%0d want 13:22:11", time_hour, time_min, time_sec);
        end
        total++; if (rd_cnt - r0 != 2 || tv_cnt - v0 != 1 || err_cnt - e0 != 1) begin
            bad++; $display("FAIL timeout_pulses: got rd=%0d tv=%0d err=%0d want 2/1/1", rd_cnt - r0, tv_cnt - v0, err_cnt - e0);
        end
    endtask

    task automatic test_merged_ticks();
        bit seen, tv, er;
        int r0, v0;
        r0 = rd_cnt; v0 = tv_cnt;
        tick_pulse();
        wait_rd(seen);
        total++; if (!seen) begin bad++; $display("FAIL merged_rd1: no read pulse"); end
        @(posedge clk_sys); #1 i2c_ready = 1'b0;
        @(posedge clk_sys); #1 tick_1hz = 1'b1;
        @(posedge clk_sys); #1 tick_1hz = 1'b0; i2c_out_valid = 1'b1; i2c_out_data = 8'h01;
        @(posedge clk_sys); #1 i2c_out_valid = 1'b0; tick_1hz = 1'b1;
        @(posedge clk_sys); #1 tick_1hz = 1'b0; i2c_out_valid = 1'b1; i2c_out_data = 8'h02;
        @(posedge clk_sys); #1 i2c_out_valid = 1'b1; i2c_out_data = 8'h03;
        @(posedge clk_sys); #1 i2c_out_valid = 1'b0;
        @(posedge clk_sys); #1 i2c_ready = 1'b1;
        total++; if ({time_valid, time_hour, time_min, time_sec} !== {1'b1, 5'd3, 6'd2, 6'd1}) begin
            bad++; $display("FAIL merged_first: got tv=%b %0d:%0d:%0d want 1 3:2:1", time_valid, time_hour, time_min, time_sec);
        end
        wait_rd(seen);
        total++; if (!seen) begin bad++; $display("FAIL merged_rd2: no follow-up read"); end
        if (seen) deliver(8'h33, 8'h44, 8'h21, 1'b1, tv, er);
        exp_s = 33; exp_m = 44; exp_h = 21;
        repeat (40) @(negedge clk_sys);
        total++; if (rd_cnt - r0 != 2 || tv_cnt - v0 != 2) begin
            bad++; $display("FAIL merged_count: got rd=%0d tv=%0d want 2/2", rd_cnt - r0, tv_cnt - v0);
        end
        total++; if ({time_hour, time_min, time_sec} !== {5'd21, 6'd44, 6'd33}) begin
            bad++; $display("FAIL merged_time: got %0d:%0d:%0d want 21:44:33", time_hour, time_min, time_sec);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int r0, v0, e0;
        tick_pulse();
        wait_rd(seen);
        total++; if (!seen) begin bad++; $display("FAIL rstmid_rd: no read pulse"); end
        @(posedge clk_sys); #1 i2c_ready = 1'b0;
        @(posedge clk_sys); #1 i2c_out_valid = 1'b1; i2c_out_data = 8'h45;
        @(posedge clk_sys); #1 i2c_out_valid = 1'b0;
        v0 = tv_cnt; e0 = err_cnt;
        reset_n = 1'b0;
        exp_s = 0; exp_m = 0; exp_h = 0;
        @(negedge clk_sys);
        total++; if ({time_hour, time_min, time_sec, time_valid, error, busy, i2c_rd_address} !== 21'd0) begin
            bad++; $display("FAIL rstmid_outputs: got %0d:%0d:%0d tv=%b err=%b busy=%b rd=%b want all 0",
                            time_hour, time_min, time_sec, time_valid, error, busy, i2c_rd_address);
        end
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
        r0 = rd_cnt;
        @(posedge clk_sys); #1 i2c_out_valid = 1'b1; i2c_out_data = 8'h59;
        @(posedge clk_sys); #1 i2c_out_valid = 1'b1; i2c_out_data = 8'h23;
        @(posedge clk_sys); #1 i2c_out_valid = 1'b0; i2c_ready = 1'b1;
        repeat (20) @(negedge clk_sys);
        total++; if (tv_cnt != v0 || err_cnt != e0 || rd_cnt != r0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_quiet: got tv=%0d err=%0d rd=%0d busy=%b want 0/0/0/0",
                            tv_cnt - v0, err_cnt - e0, rd_cnt - r0, busy);
        end
        total++; if ({time_hour, time_min, time_sec} !== {5'(exp_h), 6'(exp_m), 6'(exp_s)}) begin
            bad++; $display("FAIL rstmid_time: got %0d:%0d:%0d want 0:0:0", time_hour, time_min, time_sec);
        end
    endtask

    initial begin
        test_reset();
        test_decode_cases();
        test_random();
        test_busy_core();
        test_timeout();
        test_merged_ticks();
        test_reset_mid();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
